// File: rtl/image_dump_controller.sv
// Image dump reader/transmitter: on CMD_DUMP it streams one image buffer to uart_tx
// as SYNC, length (hi, lo), payload read through a one-deep RAM prefetch, XOR checksum.
module image_dump_controller #(
  parameter int         IMAGE_BUF_X     = 40,
  parameter int         IMAGE_BUF_Y     = 30,
  parameter int         BYTES_PER_PIXEL = 2,
  parameter logic [7:0] CMD_DUMP        = 8'hD5,
  parameter logic [7:0] SYNC_BYTE       = 8'hA5,
  parameter int         ADDR_WIDTH      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            rx_data,
  input  logic                  rx_ready,
  input  logic                  tx_busy,
  output logic [7:0]            tx_data,
  output logic                  tx_ready,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [7:0]            mem_data,
  input  logic                  mem_ready,
  output logic                  dumping,
  output logic                  dump_done,
  output logic [2:0]            dbg_state
);

  localparam int          N    = IMAGE_BUF_X * IMAGE_BUF_Y * BYTES_PER_PIXEL;
  localparam logic [15:0] LEN  = 16'(N);
  localparam logic [15:0] LAST = 16'(N - 1);

  // Handshakes: tx_ready is a 1-cycle send strobe issued only while tx_busy is low;
  // the cycle after it ignores tx_busy, and the byte is finished once tx_busy is low
  // again. mem_req with mem_addr holds steady until the mem_ready cycle, drops after.
  typedef enum logic [2:0] {S_IDLE, S_SEND, S_GAP, S_WAIT, S_DONE} state_t;
  typedef enum logic [2:0] {B_SYNC, B_LEN_HI, B_LEN_LO, B_PAY, B_CHK, B_END} sel_t;

  state_t      r_state, w_next;
  sel_t        r_sel, w_sel_next;
  logic [15:0] r_cnt, r_rd_addr;
  logic [7:0]  r_hold, r_chk, w_byte;
  logic        r_hold_full, r_req;
  logic        w_accept, w_fire, w_have_byte, w_active;
  logic        w_pay_fire, w_rd_done, w_rd_issue;

  always_comb begin
    w_byte = 8'h00;
    case (r_sel)
      B_SYNC:   w_byte = SYNC_BYTE;
      B_LEN_HI: w_byte = LEN[15:8];
      B_LEN_LO: w_byte = LEN[7:0];
      B_PAY:    w_byte = r_hold;
      B_CHK:    w_byte = r_chk;
      default:  w_byte = 8'h00;
    endcase
  end

  assign w_have_byte = (r_sel != B_PAY) || r_hold_full;

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_fire   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (rx_ready && (rx_data == CMD_DUMP)) begin
          w_accept = 1'b1;
          w_next   = S_SEND;
        end
      end
      S_SEND: begin
        if (!tx_busy && w_have_byte) begin
          w_fire = 1'b1;
          w_next = S_GAP;
        end
      end
      // Only the checksum needs its completion awaited here; other bytes wait in S_SEND.
      S_GAP:   w_next = (r_sel == B_END) ? S_WAIT : S_SEND;
      S_WAIT:  if (!tx_busy) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_sel_next = r_sel;
    if (w_fire) begin
      case (r_sel)
        B_SYNC:   w_sel_next = B_LEN_HI;
        B_LEN_HI: w_sel_next = B_LEN_LO;
        B_LEN_LO: w_sel_next = B_PAY;
        B_PAY:    w_sel_next = (r_cnt == LAST) ? B_CHK : B_PAY;
        default:  w_sel_next = B_END;
      endcase
    end
  end

  assign w_active   = (r_state == S_SEND) || (r_state == S_GAP) || (r_state == S_WAIT);
  assign w_pay_fire = w_fire && (r_sel == B_PAY);
  assign w_rd_done  = r_req && mem_ready;
  assign w_rd_issue = w_active && !r_req && !r_hold_full && (r_rd_addr != LEN);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sel       <= B_SYNC;
      r_cnt       <= '0;
      r_rd_addr   <= '0;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_req       <= 1'b0;
      r_chk       <= '0;
    end else if (w_accept) begin
      r_sel       <= B_SYNC;
      r_cnt       <= '0;
      r_rd_addr   <= '0;
      r_hold_full <= 1'b0;
      r_req       <= 1'b0;
      r_chk       <= '0;
    end else begin
      r_sel <= w_sel_next;
      if (w_pay_fire) begin
        r_cnt <= r_cnt + 16'd1;
        r_chk <= r_chk ^ r_hold;
      end
      // A read can only be outstanding while the holding register is empty,
      // so a completing read and a payload send never touch it together.
      if (w_rd_done) begin
        r_req       <= 1'b0;
        r_hold      <= mem_data;
        r_hold_full <= 1'b1;
        r_rd_addr   <= r_rd_addr + 16'd1;
      end else begin
        if (w_pay_fire) r_hold_full <= 1'b0;
        if (w_rd_issue) r_req <= 1'b1;
      end
    end
  end

  assign tx_ready  = w_fire;
  assign tx_data   = w_fire ? w_byte : 8'h00;
  assign mem_req   = r_req;
  assign mem_addr  = ADDR_WIDTH'(r_rd_addr);
  assign dumping   = w_active;
  assign dump_done = (r_state == S_DONE);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_image_dump_controller.sv
// Bench for image_dump_controller: a small (N=8) and a default (N=2400) instance share
// a UART/RAM model; captured tx bytes are compared with a frame built from the RAM image.
module tb_image_dump_controller;

  localparam int NA = 8;
  localparam int NB = 2400;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n = 1'b1;

  // ---------------- DUT connections ----------------
  logic [7:0]  rx_data   = 8'h00;
  logic        rx_ready  = 1'b0;
  logic        sel_b     = 1'b0;
  logic        busy_hold = 1'b0;
  logic        tx_busy_m = 1'b0;
  logic        tx_busy;
  logic [7:0]  mem_data  = 8'h00;
  logic        mem_ready = 1'b0;

  logic [7:0]  tx_data_a, tx_data_b;
  logic        tx_ready_a, tx_ready_b, mem_req_a, mem_req_b;
  logic [31:0] mem_addr_a, mem_addr_b;
  logic        dumping_a, dumping_b, dump_done_a, dump_done_b;
  logic [2:0]  dbg_state_a, dbg_state_b;

  logic [7:0]  m_tx_data;
  logic        m_tx_ready, m_mem_req, m_dumping, m_dump_done;
  logic [31:0] m_mem_addr;

  assign tx_busy     = busy_hold | tx_busy_m;
  assign m_tx_data   = sel_b ? tx_data_b   : tx_data_a;
  assign m_tx_ready  = sel_b ? tx_ready_b  : tx_ready_a;
  assign m_mem_req   = sel_b ? mem_req_b   : mem_req_a;
  assign m_mem_addr  = sel_b ? mem_addr_b  : mem_addr_a;
  assign m_dumping   = sel_b ? dumping_b   : dumping_a;
  assign m_dump_done = sel_b ? dump_done_b : dump_done_a;

  image_dump_controller #(.IMAGE_BUF_X(2), .IMAGE_BUF_Y(2), .BYTES_PER_PIXEL(2)) dut_a (
    .clk(clk), .reset(reset_n), .rx_data(rx_data), .rx_ready(rx_ready & ~sel_b),
    .tx_busy(tx_busy), .tx_data(tx_data_a), .tx_ready(tx_ready_a),
    .mem_req(mem_req_a), .mem_addr(mem_addr_a), .mem_data(mem_data), .mem_ready(mem_ready),
    .dumping(dumping_a), .dump_done(dump_done_a), .dbg_state(dbg_state_a)
  );

  image_dump_controller dut_b (
    .clk(clk), .reset(reset_n), .rx_data(rx_data), .rx_ready(rx_ready & sel_b),
    .tx_busy(tx_busy), .tx_data(tx_data_b), .tx_ready(tx_ready_b),
    .mem_req(mem_req_b), .mem_addr(mem_addr_b), .mem_data(mem_data), .mem_ready(mem_ready),
    .dumping(dumping_b), .dump_done(dump_done_b), .dbg_state(dbg_state_b)
  );

  // ---------------- UART / RAM model (acts on the falling edge) ----------------
  logic [7:0] ram [NB];
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  int  busy_cfg = 0, lat_cfg = 1;
  int  busy_cnt = 0, rd_wait = 0, rd_addr = 0, exp_rd = 0;
  bit  rd_busy = 1'b0, after_ready = 1'b0, mdl_clr = 1'b0;
  int  viol_busy = 0, viol_addr = 0, viol_req = 0, viol_done = 0, done_cnt = 0;

  always @(negedge clk) begin
    if (mdl_clr) begin
      busy_cnt    = 0;
      tx_busy_m   = 1'b0;
      rd_busy     = 1'b0;
      after_ready = 1'b0;
      mem_ready   = 1'b0;
      exp_rd      = 0;
    end else begin
      if (busy_cnt > 0) begin
        tx_busy_m = 1'b1;
        busy_cnt--;
      end else begin
        tx_busy_m = 1'b0;
      end
      if (mem_ready) begin
        mem_ready   = 1'b0;
        rd_busy     = 1'b0;
        after_ready = 1'b1;
      end else begin
        after_ready = 1'b0;
      end
      if (rd_busy) begin
        if (rd_wait == 0) begin
          mem_ready = 1'b1;
          mem_data  = (rd_addr < NB) ? ram[rd_addr] : 8'h00;
        end else begin
          rd_wait--;
        end
      end
    end
    #1;
    if (m_tx_ready) begin
      if (tx_busy) viol_busy++;
      got_q.push_back(m_tx_data);
      busy_cnt = busy_cfg;
    end
    if (m_mem_req) begin
      if (after_ready) begin
        viol_req++;
      end else if (!rd_busy) begin
        if (m_mem_addr != 32'(exp_rd)) viol_addr++;
        rd_busy = 1'b1;
        rd_addr = int'(m_mem_addr);
        rd_wait = lat_cfg - 1;
        exp_rd++;
      end else if (m_mem_addr != 32'(rd_addr)) begin
        viol_addr++;
      end
    end
    if (m_dump_done) begin
      done_cnt++;
      if (m_dumping) viol_done++;
    end
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic send_cmd(input logic [7:0] b);
    tick(1);
    rx_data  = b;
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
  endtask

  task automatic model_clear();
    tick(1);
    mdl_clr = 1'b1;
    tick(1);
    mdl_clr = 1'b0;
  endtask

  task automatic fill_random(input int n);
    for (int i = 0; i < n; i++) ram[i] = 8'($urandom_range(0, 255));
  endtask

  // Reference frame: sync, length hi/lo, the first n RAM bytes, XOR of those bytes.
  task automatic build_exp(input int n);
    logic [15:0] len;
    logic [7:0]  x;
    len = 16'(n);
    x   = 8'h00;
    exp_q.delete();
    exp_q.push_back(8'hA5);
    exp_q.push_back(len[15:8]);
    exp_q.push_back(len[7:0]);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(ram[i]);
      x = x ^ ram[i];
    end
    exp_q.push_back(x);
  endtask

  task automatic wait_bytes(input int target, input int budget, input string tag);
    int k;
    k = 0;
    while (got_q.size() < target && k < budget) begin
      tick(1);
      k++;
    end
    chk({tag, "_byte_timeout"}, 32'(got_q.size() >= target), 32'd1);
  endtask

  task automatic wait_done(input int start, input int budget, input string tag);
    int k;
    k = 0;
    while (done_cnt == start && k < budget) begin
      tick(1);
      k++;
    end
    chk({tag, "_done_timeout"}, 32'(done_cnt - start), 32'd1);
  endtask

  task automatic compare_stream(input string tag, input int base);
    chk({tag, "_count"}, 32'(got_q.size() - base), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (base + i < got_q.size()) chk({tag, "_byte"}, 32'(got_q[base + i]), 32'(exp_q[i]));
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_tx_while_busy"}, 32'(viol_busy), 32'd0);
    chk({tag, "_addr_order"},    32'(viol_addr), 32'd0);
    chk({tag, "_req_after_rdy"}, 32'(viol_req),  32'd0);
    chk({tag, "_done_dumping"},  32'(viol_done), 32'd0);
  endtask

  task automatic run_dump(input string tag, input int n, input int lat, input int busy);
    int base, d0;
    model_clear();
    lat_cfg  = lat;
    busy_cfg = busy;
    base     = got_q.size();
    d0       = done_cnt;
    build_exp(n);
    send_cmd(8'hD5);
    wait_done(d0, 60000, tag);
    compare_stream(tag, base);
    chk({tag, "_dumping_after"}, 32'(m_dumping), 32'd0);
    check_model(tag);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int base, d0;

    // Reset values on both instances.
    #3 reset_n = 1'b0;
    #2;
    chk("rst_tx_ready_a", 32'(tx_ready_a), 32'd0);
    chk("rst_tx_data_a",  32'(tx_data_a),  32'd0);
    chk("rst_mem_req_a",  32'(mem_req_a),  32'd0);
    chk("rst_mem_addr_a", mem_addr_a,      32'd0);
    chk("rst_dumping_a",  32'(dumping_a),  32'd0);
    chk("rst_done_a",     32'(dump_done_a), 32'd0);
    chk("rst_tx_ready_b", 32'(tx_ready_b), 32'd0);
    chk("rst_mem_req_b",  32'(mem_req_b),  32'd0);
    chk("rst_dumping_b",  32'(dumping_b),  32'd0);
    tick(3);
    reset_n = 1'b1;
    tick(2);

    // 1: N=8, RAM 01..08.
    for (int i = 0; i < NA; i++) ram[i] = 8'(i + 1);
    base = got_q.size();
    run_dump("t1", NA, 1, 3);
    if (got_q.size() >= base + 12) begin
      chk("t1_len_lo",   32'(got_q[base + 2]),  32'h08);
      chk("t1_checksum", 32'(got_q[base + 11]), 32'h08);
    end

    // 2: non-command bytes ignored; a command during a dump does not restart it.
    base = got_q.size();
    send_cmd(8'h00);
    send_cmd(8'h41);
    tick(20);
    chk("t2_no_tx", 32'(got_q.size() - base), 32'd0);
    chk("t2_idle",  32'(m_dumping), 32'd0);
    model_clear();
    fill_random(NA);
    build_exp(NA);
    lat_cfg  = 2;
    busy_cfg = 4;
    d0       = done_cnt;
    send_cmd(8'hD5);
    wait_bytes(base + 4, 500, "t2");
    send_cmd(8'hD5);
    wait_done(d0, 2000, "t2");
    compare_stream("t2", base);
    tick(100);
    chk("t2_single_dump", 32'(got_q.size() - base), 32'd12);
    chk("t2_done_once",   32'(done_cnt - d0), 32'd1);

    // 3: slow UART, RAM latency 1 then 20, same image.
    fill_random(NA);
    run_dump("t3_lat1", NA, 1, 50);
    run_dump("t3_lat20", NA, 20, 50);

    // 4: reset while payload byte 3 is on the wire.
    fill_random(NA);
    model_clear();
    lat_cfg  = 20;
    busy_cfg = 10;
    base     = got_q.size();
    send_cmd(8'hD5);
    wait_bytes(base + 7, 500, "t4");
    tick(2);
    chk("t4_req_before", 32'(m_mem_req), 32'd1);
    chk("t4_dump_before", 32'(m_dumping), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("t4_req_at_rst",   32'(m_mem_req),  32'd0);
    chk("t4_dump_at_rst",  32'(m_dumping),  32'd0);
    chk("t4_tx_at_rst",    32'(m_tx_ready), 32'd0);
    tick(3);
    reset_n = 1'b1;
    tick(60);
    chk("t4_no_tx_after", 32'(got_q.size() - base), 32'd7);
    fill_random(NA);
    run_dump("t4_after", NA, 3, 5);

    // 6: UART busy when the command arrives.
    fill_random(NA);
    model_clear();
    lat_cfg   = 1;
    busy_cfg  = 2;
    busy_hold = 1'b1;
    base      = got_q.size();
    d0        = done_cnt;
    build_exp(NA);
    send_cmd(8'hD5);
    tick(30);
    chk("t6_held_no_tx", 32'(got_q.size() - base), 32'd0);
    chk("t6_dumping",    32'(m_dumping), 32'd1);
    busy_hold = 1'b0;
    wait_done(d0, 2000, "t6");
    compare_stream("t6", base);

    // 5: default parameters, RAM all 0xFF.
    sel_b = 1'b1;
    for (int i = 0; i < NB; i++) ram[i] = 8'hFF;
    base = got_q.size();
    run_dump("t5", NB, $urandom_range(1, 4), 2);
    if (got_q.size() >= base + NB + 4) begin
      chk("t5_len_hi",   32'(got_q[base + 1]),      32'h09);
      chk("t5_len_lo",   32'(got_q[base + 2]),      32'h60);
      chk("t5_checksum", 32'(got_q[base + NB + 3]), 32'h00);
    end
    chk("t5_a_quiet", 32'(dumping_a), 32'd0);

    check_model("final");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
